// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// write-back and results returned by the multi-cycle multiply/divide unit.
// The pipeline has priority. Multiply/divide results wait in a small FIFO.
// A starvation counter forces a short pipeline stall (DRAIN) so that buffered
// results reach the register file. The committed write is registered.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data        pipeline write-back request (rd 0 = null)
//   md_valid/md_rd/md_data        multiply/divide result offer (rd 0 = drop)
//   md_ready                      FIFO can accept (from registered count only)
//   stall_wb                      pipeline must hold WB (high in DRAIN)
//   rf_we/rf_rd/rf_wdata          registered register-file write port
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int FIFO_DEPTH = 2,   // power of two, >= 2
   parameter int STARVE_MAX = 4    // >= 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        stall_wb,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wdata
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [ST_W-1:0]  STARVE_LAST = ST_W'(STARVE_MAX - 1);
   localparam logic [PTR_W-1:0] DRAIN_LAST  = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,   // FIFO empty
      S_PEND,   // FIFO holds results, pipeline still has priority
      S_DRAIN   // pipeline stalled, FIFO drains one entry per cycle
   } state_e;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
   logic [ST_W-1:0]  starve_q,    starve_d;
   logic [PTR_W-1:0] drain_cnt_q, drain_cnt_d;
   logic             rf_we_q,     rf_we_d;
   logic [4:0]       rf_rd_q,     rf_rd_d;
   logic [31:0]      rf_wdata_q,  rf_wdata_d;

   entry_t mem_q [FIFO_DEPTH];
   entry_t head;
   entry_t push_entry;

   logic fifo_empty;
   logic pipe_req;
   logic push;
   logic pop;

   assign fifo_empty = (count_q == '0);
   assign md_ready   = (count_q != CNT_FULL);
   assign stall_wb   = (state_q == S_DRAIN);

   // stall_wb masks the pipeline request, so in DRAIN the FIFO head always
   // wins; outside DRAIN the FIFO only gets the port when WB leaves it idle.
   assign pipe_req   = wb_valid & (wb_rd != '0) & ~stall_wb;
   assign push       = md_valid & md_ready & (md_rd != '0);
   assign pop        = ~pipe_req & ~fifo_empty;

   assign head       = mem_q[rd_ptr_q];
   assign push_entry = '{rd: md_rd, data: md_data};

   // Write-port grant and FIFO bookkeeping.
   always_comb begin
      // NOTE: every signal gets a default first so no path through this
      // block leaves a value unassigned, which would infer a latch.
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (pipe_req) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = wb_rd;
         rf_wdata_d = wb_data;
      end else if (pop) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = head.rd;
         rf_wdata_d = head.data;
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Starvation counter and drain FSM.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      drain_cnt_d = drain_cnt_q;

      // Counts pipeline wins over a non-empty FIFO; wraps to zero exactly
      // when the PEND -> DRAIN decision is taken.
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (pipe_req) begin
         starve_d = (starve_q == STARVE_LAST) ? '0 : starve_q + ST_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (push) state_d = S_PEND;
         end
         S_PEND: begin
            if (pipe_req && !fifo_empty && (starve_q == STARVE_LAST)) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end else if (pop && (count_q == CNT_ONE) && !push) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + PTR_W'(1);
            // Leave when this pop takes the last entry or after FIFO_DEPTH
            // drain cycles; a same-cycle push keeps the FIFO non-empty.
            if ((count_q == CNT_ONE) || (drain_cnt_q == DRAIN_LAST)) begin
               state_d = (count_d == '0) ? S_IDLE : S_PEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      if (!reset_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         starve_q    <= '0;
         drain_cnt_q <= '0;
         rf_we_q     <= 1'b0;
         rf_rd_q     <= '0;
         rf_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         starve_q    <= starve_d;
         drain_cnt_q <= drain_cnt_d;
         rf_we_q     <= rf_we_d;
         rf_rd_q     <= rf_rd_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // NOTE: the storage array has no reset; resetting count and pointers is
   // enough to discard its contents, since an entry is only read after it
   // has been written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Owns the single register-file write port and shares it between the in-order pipeline write-back (the WB stage `xd` result) and results returned by the multi-cycle multiply/divide unit. The pipeline has priority; multiply/divide results wait in a small FIFO. A starvation counter forces a short pipeline stall so that buffered results drain. The block sits between WB and the register file and registers the write it commits.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: multiply/divide result buffer entries. Must be a power of two and ≥ 2.
- `STARVE_MAX`, default 4: number of consecutive blocked cycles of the FIFO head before a forced drain. Must be ≥ 1.

Ports:
- `clk`  in  1  sole clock. All state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_valid`  in  1  pipeline write-back request this cycle.
- `wb_rd`  in  5  pipeline destination register.
- `wb_data`  in  32  pipeline write data (WB `xd`).
- `md_valid`  in  1  multiply/divide result offered.
- `md_rd`  in  5  multiply/divide destination register.
- `md_data`  in  32  multiply/divide result.
- `md_ready`  out  1  FIFO can accept; a transfer occurs when `md_valid & md_ready`.
- `stall_wb`  out  1  pipeline must hold WB; `wb_valid` is ignored while this is high.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_rd`  out  5  register-file write address (registered).
- `rf_wdata`  out  32  register-file write data (registered).

## Operation
**Request classes**
- Pipeline request: `wb_valid=1`, `wb_rd≠0`, and `stall_wb=0`.
- A `wb_valid` with `wb_rd=0` is a null request. It never writes and never blocks the FIFO.
- A multiply/divide transfer with `md_rd=0` is accepted and discarded; nothing is pushed.

**FIFO**
- `md_ready = (count != FIFO_DEPTH)`, decoded from registered count only; it is not affected by a same-cycle pop.
- Push and pop in the same cycle are legal; count is unchanged.
- Entries are written in arrival order.

**Grant, each cycle (priority order)**
1. State DRAIN, FIFO non-empty: pop the head and write it.
2. Pipeline request present: write it.
3. FIFO non-empty: pop the head and write it.
4. Otherwise: no write.

**Starvation counter** `starve` (0..STARVE_MAX-1)
- Increments when the FIFO is non-empty and the pipeline wins the port.
- Cleared on any FIFO pop and whenever the FIFO is empty.

**States**
- IDLE: FIFO empty. `stall_wb=0`. Goes to PEND when the FIFO becomes non-empty (a push with no pop).
- PEND: FIFO non-empty. `stall_wb=0`.
  - If a pipeline grant occurs while `starve==STARVE_MAX-1`, go to DRAIN and clear `starve`.
  - If a pop empties the FIFO with no push, go to IDLE.
- DRAIN: `stall_wb=1` (Moore output). Pops one entry per cycle.
  - Exits when a pop leaves the FIFO empty: to IDLE, or to PEND if a push happened in the same cycle.
  - Also exits after `FIFO_DEPTH` drain cycles, whichever comes first: to PEND, or to IDLE if the FIFO is empty.
- The starvation-counter, FIFO-depth and register-index rules above are the complete set of arithmetic and width rules.

**Ownership of hazards**
- Write-after-write and read-after-write hazards against buffered results belong to the hazard unit's scoreboard, not to this block.
- The block guarantees that every accepted nonzero-`rd` result is written exactly once.

## Timing
- **Reset (`reset_n=0`, asynchronous):**
  - `rf_we=0`, `rf_rd=0`, `rf_wdata=0`, `stall_wb=0`, `md_ready=1`.
  - State IDLE, count 0, `starve=0`.
  - FIFO contents are discarded, including on reset mid-drain.
  - Deassertion is taken at the next `clk` edge.
- **Write latency:**
  - A grant in cycle N appears on `rf_*` during cycle N+1, with `rf_we=1` for exactly one cycle.
  - In a no-write cycle, `rf_we=0`; `rf_rd` and `rf_wdata` hold their previous values.
- **Multiply/divide path:**
  - A result pushed in cycle N is eligible for grant in cycle N+1 at the earliest.
  - There is no bypass from `md_*` to `rf_*` in the same cycle.
- **Stall timing:**
  - `stall_wb` rises in the cycle after the DRAIN decision.
  - It stays high for 1..`FIFO_DEPTH` cycles.
  - It falls in the cycle after the exit condition.
- **Full FIFO:**
  - `md_ready=0`. The unit must hold `md_*` stable until it sees `md_ready=1`.
  - A pop while full raises `md_ready` in the next cycle.

## Test plan
1. **Pipeline write:** `wb_valid=1`, `wb_rd=5`, `wb_data=0xDEADBEEF` in cycle 1. Required: `rf_we=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF` in cycle 2; `stall_wb=0` throughout.
2. **Idle-port drain:** `md_valid=1`, `md_rd=7`, `md_data=0x12345678` in cycle 1; `wb_valid=0` afterwards. Required: `rf_we=1`, `rf_rd=7` in cycle 3; FIFO empty and state IDLE afterwards.
3. **Starvation:**
   - Stimulus: push `md_rd=9`, then hold `wb_valid=1` with `wb_rd` incrementing from 1, with `STARVE_MAX=4`.
   - Required: four pipeline writes, then `stall_wb=1` for exactly one cycle, during which `rf_rd=9` is written next cycle. Pipeline writes resume after `stall_wb` falls.
4. **Full FIFO:**
   - Stimulus: three back-to-back md results (`rd`=10, 11, 12) with continuous pipeline traffic, `FIFO_DEPTH=2`.
   - Required: `md_ready=0` after the second push. The third result is held and accepted only after a pop. Writes appear in order 10, 11, 12; no loss, no duplicate.
5. **Register zero:** `wb_rd=0` with `wb_valid=1`, plus an md transfer with `md_rd=0`. Required: `rf_we` never asserts; the FIFO stays empty; `md_ready` stays 1.
6. **Reset mid-drain:**
   - Stimulus: pull `reset_n` low while in DRAIN with two entries buffered.
   - Required: `stall_wb=0`, `rf_we=0`, `md_ready=1` immediately. No buffered entry is written after reset is released.
